// File: rtl/edubos5_pkg.sv
// eduBOS5 shared types: CPU word types, load/store funct3 encodings,
// byte-lane write-enable patterns and the LSU state encoding.
package edubos5_pkg;

  typedef logic [31:0] cpu_addr_t;
  typedef logic [31:0] cpu_data_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } funct3_load_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } funct3_store_t;

  typedef logic [3:0] we_bs_t;
  localparam we_bs_t NOWR      = 4'b0000;
  localparam we_bs_t BYTE1     = 4'b0001;
  localparam we_bs_t BYTE2     = 4'b0010;
  localparam we_bs_t BYTE3     = 4'b0100;
  localparam we_bs_t BYTE4     = 4'b1000;
  localparam we_bs_t HALFWORD1 = 4'b0011;
  localparam we_bs_t HALFWORD2 = 4'b1100;
  localparam we_bs_t WORD      = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  function automatic cpu_data_t ext_byte(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic cpu_data_t ext_half(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/edubos5_lsu_align.sv
// Combinational lane logic for the LSU: store byte enables and data replication,
// load byte/halfword extraction with extension, misalign and illegal detection.
module edubos5_lsu_align
  import edubos5_pkg::*;
(
  input  logic        load,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  cpu_data_t   wdata,
  input  cpu_data_t   rdata,
  output logic [3:0]  we_bs,
  output cpu_data_t   wdata_lanes,
  output cpu_data_t   rdata_fmt,
  output logic        misalign,
  output logic        illegal
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rdata[{addr_lo, 3'b000} +: 8];
  assign half_s = rdata[{addr_lo[1], 4'b0000} +: 16];

  // decode funct3 into lanes, formatted read data and error flags
  always_comb begin
    we_bs       = NOWR;
    wdata_lanes = 32'h0000_0000;
    rdata_fmt   = 32'h0000_0000;
    misalign    = 1'b0;
    illegal     = 1'b0;
    if (load) begin
      case (funct3)
        LB:  rdata_fmt = ext_byte(byte_s, 1'b1);
        LBU: rdata_fmt = ext_byte(byte_s, 1'b0);
        LH: begin
          misalign  = addr_lo[0];
          rdata_fmt = ext_half(half_s, 1'b1);
        end
        LHU: begin
          misalign  = addr_lo[0];
          rdata_fmt = ext_half(half_s, 1'b0);
        end
        LW: begin
          misalign  = (addr_lo != 2'b00);
          rdata_fmt = rdata;
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        SB: begin
          we_bs       = BYTE1 << addr_lo;
          wdata_lanes = {4{wdata[7:0]}};
        end
        SH: begin
          misalign    = addr_lo[0];
          we_bs       = addr_lo[1] ? HALFWORD2 : HALFWORD1;
          wdata_lanes = {2{wdata[15:0]}};
        end
        SW: begin
          misalign    = (addr_lo != 2'b00);
          we_bs       = WORD;
          wdata_lanes = wdata;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/edubos5_lsu.sv
// eduBOS5 load/store unit: one bus transaction at a time with byte lanes,
// formatted load writeback, and misalign/illegal/timeout reporting.
module edubos5_lsu
  import edubos5_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        bus_req,
  output logic [3:0]  bus_we_bs,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        rsp_valid,
  output logic        rsp_we,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic        rsp_misalign,
  output logic        rsp_illegal,
  output logic        rsp_buserr
);

  localparam int unsigned      CNT_W    = $clog2(ACK_TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam bit               TO_EN    = (ACK_TIMEOUT != 32'd0);

  lsu_state_t       state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             load_r, req_ready_r, bus_req_r;
  logic [2:0]       funct3_r;
  logic [1:0]       off_r;
  logic [4:0]       rd_r, rsp_rd_r;
  logic [3:0]       bus_we_bs_r;
  cpu_addr_t        bus_addr_r;
  cpu_data_t        bus_wdata_r, rsp_data_r;
  logic             rsp_valid_r, rsp_we_r, rsp_misalign_r, rsp_illegal_r, rsp_buserr_r;

  logic             idle_s, accept_s, timeout_s, err_s;
  logic             al_load_s, misalign_s, illegal_s;
  logic [2:0]       al_funct3_s;
  logic [1:0]       al_off_s;
  logic [3:0]       we_bs_s;
  cpu_data_t        wdata_lanes_s, rdata_fmt_s;

  assign idle_s    = (state_r == IDLE);
  assign accept_s  = idle_s & req_valid;
  assign timeout_s = TO_EN & (cnt_r == CNT_LAST);
  assign err_s     = illegal_s | misalign_s;

  // the request is decoded live while idle; the held copy drives load formatting
  assign al_load_s   = idle_s ? req_load      : load_r;
  assign al_funct3_s = idle_s ? req_funct3    : funct3_r;
  assign al_off_s    = idle_s ? req_addr[1:0] : off_r;

  edubos5_lsu_align u_align (
    .load        (al_load_s),
    .funct3      (al_funct3_s),
    .addr_lo     (al_off_s),
    .wdata       (req_wdata),
    .rdata       (bus_rdata),
    .we_bs       (we_bs_s),
    .wdata_lanes (wdata_lanes_s),
    .rdata_fmt   (rdata_fmt_s),
    .misalign    (misalign_s),
    .illegal     (illegal_s)
  );

  // next-state selection
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_s = err_s ? RESP : BUS;
        end else begin
          state_s = IDLE;
        end
      end
      BUS: begin
        if (bus_ack || timeout_s) begin
          state_s = RESP;
        end else begin
          state_s = BUS;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      req_ready_r <= (state_s == IDLE);
    end
  end

  // request capture, bus drive, timeout counter and response pulse
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_r          <= '0;
      load_r         <= 1'b0;
      funct3_r       <= 3'b000;
      off_r          <= 2'b00;
      rd_r           <= 5'd0;
      bus_req_r      <= 1'b0;
      bus_we_bs_r    <= NOWR;
      bus_addr_r     <= 32'h0000_0000;
      bus_wdata_r    <= 32'h0000_0000;
      rsp_valid_r    <= 1'b0;
      rsp_we_r       <= 1'b0;
      rsp_rd_r       <= 5'd0;
      rsp_data_r     <= 32'h0000_0000;
      rsp_misalign_r <= 1'b0;
      rsp_illegal_r  <= 1'b0;
      rsp_buserr_r   <= 1'b0;
    end else begin
      rsp_valid_r    <= 1'b0;
      rsp_we_r       <= 1'b0;
      rsp_rd_r       <= 5'd0;
      rsp_data_r     <= 32'h0000_0000;
      rsp_misalign_r <= 1'b0;
      rsp_illegal_r  <= 1'b0;
      rsp_buserr_r   <= 1'b0;
      if (accept_s) begin
        load_r   <= req_load;
        funct3_r <= req_funct3;
        off_r    <= req_addr[1:0];
        rd_r     <= req_rd;
        cnt_r    <= '0;
        if (err_s) begin
          rsp_valid_r    <= 1'b1;
          rsp_rd_r       <= req_rd;
          rsp_illegal_r  <= illegal_s;
          rsp_misalign_r <= ~illegal_s & misalign_s;
        end else begin
          bus_req_r   <= 1'b1;
          bus_addr_r  <= {req_addr[31:2], 2'b00};
          bus_we_bs_r <= we_bs_s;
          bus_wdata_r <= wdata_lanes_s;
        end
      end else if (state_r == BUS) begin
        if (bus_ack || timeout_s) begin
          bus_req_r    <= 1'b0;
          bus_we_bs_r  <= NOWR;
          rsp_valid_r  <= 1'b1;
          rsp_rd_r     <= rd_r;
          rsp_buserr_r <= ~bus_ack;
          rsp_data_r   <= (bus_ack && load_r) ? rdata_fmt_s : 32'h0000_0000;
          rsp_we_r     <= bus_ack & load_r & (rd_r != 5'd0);
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign req_ready    = req_ready_r;
  assign bus_req      = bus_req_r;
  assign bus_we_bs    = bus_we_bs_r;
  assign bus_addr     = bus_addr_r;
  assign bus_wdata    = bus_wdata_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_we       = rsp_we_r;
  assign rsp_rd       = rsp_rd_r;
  assign rsp_data     = rsp_data_r;
  assign rsp_misalign = rsp_misalign_r;
  assign rsp_illegal  = rsp_illegal_r;
  assign rsp_buserr   = rsp_buserr_r;

endmodule

// File: tb/tb_edubos5_lsu.sv
// Self-checking bench for edubos5_lsu: directed cases plus randomized requests
// checked against a byte-level reference model of load/store behaviour.
module tb_edubos5_lsu;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        arst;
  logic        req_valid, req_ready, req_load;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        bus_req, bus_ack;
  logic [3:0]  bus_we_bs;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        rsp_valid, rsp_we, rsp_misalign, rsp_illegal, rsp_buserr;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_errors = 0;

  edubos5_lsu #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .arst(arst),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .bus_req(bus_req), .bus_we_bs(bus_we_bs), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
    .rsp_misalign(rsp_misalign), .rsp_illegal(rsp_illegal), .rsp_buserr(rsp_buserr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic scramble_req();
    req_load   = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_rd     = 5'($urandom);
  endtask

  // Issue one request at the current negedge (LSU idle) and check it to completion.
  // ack_dly: index of the BUS cycle carrying bus_ack; >= T means no ack at all.
  task automatic run_req(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input int ack_dly,
                         input logic [31:0] rdat);
    int          size, off, cyc, guard;
    bit          done, ill, mis, berr;
    logic [3:0]  exp_we;
    logic [31:0] exp_wd, exp_ld, exp_data;
    size   = 1 << f3[1:0];
    off    = int'(addr[1:0]);
    ill    = ld ? (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) : (f3 > 3'd2);
    mis    = !ill && ((off % size) != 0);
    exp_we = 4'b0000;
    exp_wd = 32'h0;
    exp_ld = 32'h0;
    if (!ill && !mis) begin
      for (int j = 0; j < 4; j++) begin
        exp_we[j] = !ld && (j >= off) && (j < off + size);
        exp_wd[8*j +: 8] = wd[8*(j % size) +: 8];
      end
      for (int i = 0; i < size; i++) exp_ld[8*i +: 8] = rdat[8*(off+i) +: 8];
      if (!f3[2] && size < 4 && exp_ld[8*size-1])
        for (int i = size; i < 4; i++) exp_ld[8*i +: 8] = 8'hFF;
    end
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("ready_before_req", 32'(req_ready), 32'(1'b1));
    req_valid = 1'b1; req_load = ld; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0;
    scramble_req();
    berr = 1'b0;
    if (ill || mis) begin
      check_eq("err_no_bus", 32'(bus_req), 32'(1'b0));
    end else begin
      cyc  = 0;
      done = 1'b0;
      while (!done) begin
        check_eq("bus_req_high", 32'(bus_req), 32'(1'b1));
        check_eq("no_rsp_in_bus", 32'(rsp_valid), 32'(1'b0));
        check_eq("bus_addr", bus_addr, {addr[31:2], 2'b00});
        check_eq("bus_we_bs", 32'(bus_we_bs), 32'(exp_we));
        if (!ld) check_eq("bus_wdata", bus_wdata, exp_wd);
        if (cyc == ack_dly) begin
          bus_ack = 1'b1; bus_rdata = rdat;
        end else begin
          bus_ack = 1'b0;
        end
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        if (cyc == ack_dly) begin
          done = 1'b1;
        end else if (cyc == T - 1) begin
          done = 1'b1;
          berr = 1'b1;
        end
        cyc++;
      end
    end
    exp_data = (ld && !ill && !mis && !berr) ? exp_ld : 32'h0;
    check_eq("rsp_valid", 32'(rsp_valid), 32'(1'b1));
    check_eq("bus_req_low_in_rsp", 32'(bus_req), 32'(1'b0));
    check_eq("rsp_illegal", 32'(rsp_illegal), 32'(ill));
    check_eq("rsp_misalign", 32'(rsp_misalign), 32'(mis));
    check_eq("rsp_buserr", 32'(rsp_buserr), 32'(berr));
    check_eq("rsp_data", rsp_data, exp_data);
    check_eq("rsp_we", 32'(rsp_we), 32'(ld && !ill && !mis && !berr && rd != 5'd0));
    check_eq("rsp_rd", 32'(rsp_rd), 32'(rd));
    bus_ack = 1'($urandom);
    @(negedge clk);
    bus_ack = 1'b0;
    check_eq("rsp_one_pulse", 32'(rsp_valid), 32'(1'b0));
    check_eq("ready_after_rsp", 32'(req_ready), 32'(1'b1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          lsel;
    arst = 1'b1; req_valid = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    req_load = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    #3;
    check_eq("rst_ready", 32'(req_ready), 32'(1'b1));
    check_eq("rst_bus_req", 32'(bus_req), 32'(1'b0));
    check_eq("rst_we_bs", 32'(bus_we_bs), 32'h0);
    check_eq("rst_bus_addr", bus_addr, 32'h0);
    check_eq("rst_bus_wdata", bus_wdata, 32'h0);
    check_eq("rst_rsp", {rsp_data[31:0]}, 32'h0);
    check_eq("rst_rsp_flags", 32'({rsp_valid, rsp_we, rsp_rd, rsp_misalign, rsp_illegal, rsp_buserr}), 32'h0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);

    // directed cases
    run_req(1'b0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 5'd1, 0, 32'h0);
    run_req(1'b1, 3'b000, 32'h0000_0201, 32'h0, 5'd5, 0, 32'h1234_80FF);
    run_req(1'b1, 3'b100, 32'h0000_0201, 32'h0, 5'd6, 1, 32'h1234_80FF);
    run_req(1'b1, 3'b001, 32'h0000_0202, 32'h0, 5'd7, 2, 32'h1234_80FF);
    run_req(1'b1, 3'b010, 32'h0000_0006, 32'h0, 5'd3, 0, 32'h0);
    run_req(1'b1, 3'b111, 32'h0000_0010, 32'h0, 5'd4, 0, 32'h0);
    run_req(1'b1, 3'b010, 32'h0000_0040, 32'h0, 5'd8, 9, 32'h0);
    run_req(1'b1, 3'b010, 32'h0000_0044, 32'h0, 5'd9, 3, 32'hCAFE_F00D);
    run_req(1'b0, 3'b001, 32'h0000_0082, 32'h0000_BEEF, 5'd2, 1, 32'h0);
    run_req(1'b1, 3'b010, 32'h0000_0050, 32'h0, 5'd0, 0, 32'h1111_2222);

    // bus_ack while idle must be ignored
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    check_eq("idle_ack_bus_req", 32'(bus_req), 32'(1'b0));
    check_eq("idle_ack_rsp", 32'(rsp_valid), 32'(1'b0));
    check_eq("idle_ack_ready", 32'(req_ready), 32'(1'b1));

    // arst during BUS aborts the access without a response
    req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0020; req_rd = 5'd10;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("arst_pre_bus_req", 32'(bus_req), 32'(1'b1));
    #2 arst = 1'b1;
    #1;
    check_eq("arst_bus_req_async", 32'(bus_req), 32'(1'b0));
    check_eq("arst_ready_async", 32'(req_ready), 32'(1'b1));
    #1 arst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("arst_no_rsp", 32'(rsp_valid), 32'(1'b0));
      check_eq("arst_bus_idle", 32'(bus_req), 32'(1'b0));
    end
    run_req(1'b1, 3'b010, 32'h0000_0010, 32'h0, 5'd11, 0, 32'hDEAD_BEEF);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      ld = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        lsel = $urandom_range(0, 4);
        f3 = ld ? ((lsel > 2) ? 3'(lsel + 1) : 3'(lsel)) : 3'($urandom_range(0, 2));
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      run_req(ld, f3, addr, $urandom, 5'($urandom), $urandom_range(0, 5), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
